grid_scan_reader: RTL
=====================

# grid_scan_reader

Read-side counterpart to the per-clock grid copy stage of the cellular-grid pipeline. On `start`, takes a one-cycle snapshot of the flattened N×M cell array and streams it out one cell per transfer over a valid/ready handshake, in row-major order with row/column coordinates and frame markers. Also reports a running and final live-cell count. It sits between the grid register and any serial consumer (display driver, UART dump, checker), so the grid can keep updating while a consistent frame is read out.

## Interface
Parameters:
- `N`, 40, columns per row
- `M`, 25, rows
- `RW`, clog2(M) = 5, row index width
- `CW`, clog2(N) = 6, column index width
- `LW`, clog2(N*M+1) = 10, live-count width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `grid`  in  N*M  flattened cell array; cell (r,c) is bit r*N+c
- `start`  in  1  request a frame readout; sampled only in IDLE
- `busy`  out  1  high from the cycle after accepted start until done
- `cell_valid`  out  1  output cell is presented
- `cell_ready`  in  1  consumer accepts the presented cell
- `cell_data`  out  1  value of presented cell
- `cell_row`  out  RW  row of presented cell
- `cell_col`  out  CW  column of presented cell
- `cell_first`  out  1  presented cell is (0,0)
- `cell_last`  out  1  presented cell is (M-1,N-1)
- `done`  out  1  one-cycle pulse after last cell accepted
- `live_count`  out  LW  number of accepted cells with data=1 in current/last frame

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: `start`=1 → copy `grid` into internal snapshot register, clear row/col and `live_count`, go to SCAN. `start`=0 → stay.
- SCAN: `cell_valid`=1. Outputs driven from snapshot bit row*N+col. A transfer occurs when `cell_valid && cell_ready`.
  - On transfer: `live_count` += `cell_data`; col increments; col=N-1 wraps to 0 and row increments.
  - Transfer with row=M-1, col=N-1 → go to DONE.
  - No transfer → all outputs held stable (data, row, col, markers).
- DONE: one cycle; `done`=1, `cell_valid`=0; → IDLE unconditionally.
- `start` in SCAN or DONE ignored (not queued).
- Snapshot is frozen for the whole frame; changes on `grid` after the start cycle never affect output.
- `live_count` holds its final value in IDLE until the next accepted start clears it.
- `cell_first`/`cell_last` are decoded from row/col and valid only while `cell_valid`=1; forced 0 otherwise.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; `busy`, `cell_valid`, `done`, `cell_data`, `cell_first`, `cell_last` = 0; `cell_row`, `cell_col`, `live_count` = 0; snapshot cleared. Reset mid-frame aborts immediately, no `done`.
- Start latency: `start` high in IDLE at edge k → `busy`=1 and `cell_valid`=1 with cell (0,0) from edge k+1.
- Throughput: one cell per cycle with `cell_ready` held high; full frame = N*M cycles of valid.
- Last transfer at edge t → at edge t+1: `cell_valid`=0, `done`=1, `busy`=1; at edge t+2: `done`=0, `busy`=0, IDLE; earliest new start sampled at edge t+2.
- `cell_valid` never drops without a transfer; no combinational path from `cell_ready` to `cell_valid`.
- All outputs registered.

## Structure
- Shared package: default `N`, `M`, derived widths `RW`, `CW`, `LW`, FSM state encoding; the copy stage and this block import the same `N`/`M`.
- One natural sub-module: `grid_rc_counter` — row/col counter with enable, synchronous clear, column wrap at N-1 and terminal flag at (M-1,N-1).

## Test plan
- Reset then idle, `start`=0 for 10 cycles → `busy`=0, `cell_valid`=0, `live_count`=0 throughout.
- Checkerboard grid (bit=(r+c)&1), `start` once, `cell_ready`=1 → 1000 cells in row-major order, data matches, first at (0,0), last at (24,39), `done` one cycle after, `live_count`=500.
- All-ones grid, `cell_ready` toggled randomly (~50%) → outputs stable while stalled, exactly 1000 transfers, `live_count`=1000.
- Grid changed to all-zero the cycle after start, and `start` pulsed mid-frame → streamed data matches original snapshot, no second frame begins.
- `rst` asserted at cell (10,5) → all outputs 0 immediately, no `done`; new start afterwards streams from (0,0) with `live_count` restarting at 0.
- Single live cell at (24,39) → `live_count` stays 0 until final transfer, becomes 1 with `done`.

Source files
------------

// File: rtl/grid_scan_reader_pkg.sv
// Shared grid dimensions, derived index widths and the scan FSM encoding.
// The copy stage and the scan reader import the same N/M from here.
package grid_scan_reader_pkg;

    localparam int GRID_N  = 40;
    localparam int GRID_M  = 25;
    localparam int GRID_RW = $clog2(GRID_M);
    localparam int GRID_CW = $clog2(GRID_N);
    localparam int GRID_LW = $clog2(GRID_N * GRID_M + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/grid_rc_counter.sv
// Row-major row/column position counter with synchronous clear.
// Columns wrap at N-1; term flags (M-1,N-1), where the counter returns to (0,0).
module grid_rc_counter #(
    parameter int N  = 40,
    parameter int M  = 25,
    parameter int RW = 5,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          term
);

    assign term = (row == RW'(M - 1)) && (col == CW'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == CW'(N - 1)) begin
                col <= '0;
                row <= term ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_scan_reader.sv
// Snapshots the flattened cell grid on start and streams it out one cell per
// transfer in row-major order, counting live cells as they are accepted.
module grid_scan_reader
    import grid_scan_reader_pkg::*;
#(
    parameter int N  = GRID_N,
    parameter int M  = GRID_M,
    parameter int RW = $clog2(M),
    parameter int CW = $clog2(N),
    parameter int LW = $clog2(N * M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*M-1:0] grid,
    input  logic          start,
    output logic          busy,
    output logic          cell_valid,
    input  logic          cell_ready,
    output logic          cell_data,
    output logic [RW-1:0] cell_row,
    output logic [CW-1:0] cell_col,
    output logic          cell_first,
    output logic          cell_last,
    output logic          done,
    output logic [LW-1:0] live_count
);

    // Handshake: a cell transfers on a rising edge where cell_valid && cell_ready.
    // cell_valid depends only on the state register, so it never falls without a
    // transfer and has no path from cell_ready; a stalled cell is held unchanged.

    scan_state_t    state_q, state_d;
    logic [N*M-1:0] snap;
    logic           load, adv, term;
    logic [LW-1:0]  idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cell_ready) begin
                    adv = 1'b1;
                    if (term) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    grid_rc_counter #(.N(N), .M(M), .RW(RW), .CW(CW)) u_rc (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (adv),
        .row  (cell_row),
        .col  (cell_col),
        .term (term)
    );

    // The snapshot is only written on an accepted start, so grid changes mid-frame are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap       <= '0;
            live_count <= '0;
        end else if (load) begin
            snap       <= grid;
            live_count <= '0;
        end else if (adv) begin
            live_count <= live_count + LW'(cell_data);
        end
    end

    assign idx        = LW'(cell_row) * LW'(N) + LW'(cell_col);
    assign busy       = (state_q != ST_IDLE);
    assign cell_valid = (state_q == ST_SCAN);
    assign done       = (state_q == ST_DONE);
    assign cell_data  = cell_valid && snap[idx];
    assign cell_first = cell_valid && (cell_row == '0) && (cell_col == '0);
    assign cell_last  = cell_valid && term;

endmodule
